// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR capture block: default geometry,
// the MISR feedback taps and small sizing/update helpers.
package lfsr_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;

  // Feedback taps for x^32 + x^22 + x^2 + x + 1 (bits 31, 21, 1, 0).
  localparam logic [31:0] MISR_TAPS = 32'h8020_0003;

  // Occupancy counter width: must be able to hold DEPTH itself.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // One MISR step: shift left, feed back the tap parity, fold in the word.
  function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                            input logic [31:0] din);
    return {sig[30:0], ^(sig & MISR_TAPS)} ^ din;
  endfunction

endpackage

// File: rtl/lfsr_capture_fifo.sv
// Word FIFO for the LFSR capture block. A push while full is accepted only
// when a pop happens on the same edge; a pop while empty is ignored.
module lfsr_capture_fifo
  import lfsr_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] data_in,
  output logic [WORD_W-1:0] data_out,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = occ_w(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              do_push;
  logic              do_pop;

  assign full     = (occ_q == OCC_W'(DEPTH));
  assign empty    = (occ_q == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign data_out = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      occ_d = occ_q + OCC_W'(1);
    else if (!do_push && do_pop) occ_d = occ_q - OCC_W'(1);
  end

  // Control state: cleared asynchronously so the FIFO reads empty in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage: data only, never read while empty so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/lfsr_capture.sv
// LFSR capture: deserializes a sampled serial stream MSB-first into
// WORD_W-bit words, queues them in a small FIFO, counts pushes, flags
// drops and (optionally) folds every accepted word into a 32-bit MISR.
// Optional feature macro: LFSR_CAPTURE_SIGNATURE_EN enables the MISR;
// without it sig_out is tied to zero.
module lfsr_capture
  import lfsr_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d,
  input  logic              sample_en,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              overflow,
  output logic [15:0]       word_count,
  output logic [31:0]       sig_out
);

  localparam int CNT_W = $clog2(WORD_W);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       word_count_q, word_count_d;
  logic [WORD_W-1:0] push_word;
  logic              push;
  logic              pop;
  logic              accepted;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_head;

  // Deserializer: shift on sample_en, push the word on its last bit.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    push      = 1'b0;
    push_word = {shift_q[WORD_W-2:0], d};
    if (sample_en) begin
      shift_d = push_word;
      if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
        bit_cnt_d = '0;
        push      = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  // A pop needs a head word; a push while full only lands if a pop frees a slot.
  assign pop      = ~fifo_empty & word_ready;
  assign accepted = push & (~fifo_full | pop);

  // Push counter and sticky drop flag.
  always_comb begin
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    if (accepted)                    word_count_d = word_count_q + 16'd1;
    if (push && fifo_full && !pop)   overflow_d   = 1'b1;
  end

  // Deserializer and counter state; reset discards any partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
    end
  end

  lfsr_capture_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .data_in  (push_word),
    .data_out (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign word_valid = ~fifo_empty;
  assign word_out   = fifo_empty ? '0 : fifo_head;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

`ifdef LFSR_CAPTURE_SIGNATURE_EN
  logic [31:0] sig_q, sig_d;

  // MISR next-state: fold in each word that actually entered the FIFO.
  always_comb begin
    sig_d = sig_q;
    if (accepted) sig_d = misr_next(sig_q, 32'(push_word));
  end

  // MISR register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig_out = sig_q;
`else
  assign sig_out = '0;
`endif

endmodule

// File: tb/tb_lfsr_capture.sv
// Testbench for lfsr_capture: directed scenarios followed by a random
// phase, all compared every cycle against a queue-based reference model.
module tb_lfsr_capture;

  localparam int WORD_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              d;
  logic              sample_en;
  logic              word_ready;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              overflow;
  logic [15:0]       word_count;
  logic [31:0]       sig_out;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] m_q[$];
  int          m_nbits;
  logic [31:0] m_part;
  logic        m_ovf;
  logic [15:0] m_cnt;
  logic [31:0] m_sig;

  lfsr_capture #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .sample_en  (sample_en),
    .word_ready (word_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .overflow   (overflow),
    .word_count (word_count),
    .sig_out    (sig_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_nbits = 0;
    m_part  = '0;
    m_ovf   = 1'b0;
    m_cnt   = '0;
    m_sig   = '0;
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_edge(input logic din, input logic se, input logic rdy);
    bit          do_pop;
    bit          have_word;
    logic [31:0] w;
    if (!reset) begin
      model_reset();
      return;
    end
    do_pop    = (m_q.size() > 0) && rdy;
    have_word = 0;
    w         = '0;
    if (se) begin
      m_part = (m_part << 1) | 32'(din);
      m_nbits++;
      if (m_nbits == WORD_W) begin
        have_word = 1;
        w         = m_part;
        m_nbits   = 0;
        m_part    = '0;
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (have_word) begin
      if (m_q.size() == DEPTH) begin
        m_ovf = 1'b1;
      end else begin
        m_q.push_back(w);
        m_cnt = m_cnt + 16'd1;
`ifdef LFSR_CAPTURE_SIGNATURE_EN
        m_sig = {m_sig[30:0], m_sig[31] ^ m_sig[21] ^ m_sig[1] ^ m_sig[0]} ^ w;
`endif
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_word;
    exp_word = (m_q.size() > 0) ? m_q[0] : 32'h0;
    chk({tag, ".word_valid"}, 32'(word_valid), 32'(m_q.size() > 0));
    chk({tag, ".word_out"},   word_out, exp_word);
    chk({tag, ".overflow"},   32'(overflow), 32'(m_ovf));
    chk({tag, ".word_count"}, 32'(word_count), 32'(m_cnt));
    chk({tag, ".sig_out"},    sig_out, m_sig);
  endtask

  // Drive inputs, take one edge, update the model, check 1 ns later.
  task automatic step(input logic din, input logic se, input logic rdy, input string tag);
    d = din; sample_en = se; word_ready = rdy;
    @(posedge clk);
    model_edge(din, se, rdy);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #2;
    check_all("reset_pulse");
    reset = 1'b1;
  endtask

  // Serialize a word MSB-first; optional idle cycle before each bit.
  task automatic send_word(input logic [31:0] w, input logic rdy, input bit gap,
                           input logic rdy_last, input string tag);
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (gap) step(1'($urandom), 1'b0, rdy, tag);
      step(w[i], 1'b1, (i == 0) ? rdy_last : rdy, tag);
    end
  endtask

  initial begin
    reset = 1'b0; d = 1'b0; sample_en = 1'b0; word_ready = 1'b0;
    model_reset();

    // Held in reset with activity on the inputs: everything stays zero.
    for (int i = 0; i < 8; i++) begin
      step(1'(i), 1'b1, 1'b1, "in_reset");
      chk("in_reset.valid_zero", 32'(word_valid), 32'h0);
      chk("in_reset.out_zero", word_out, 32'h0);
    end
    reset = 1'b1;

    // Single word, consumer always ready.
    send_word(32'hA5A5F00F, 1'b1, 0, 1'b1, "single");
    chk("single.valid", 32'(word_valid), 32'h1);
    chk("single.word", word_out, 32'hA5A5F00F);
    step(1'b0, 1'b0, 1'b1, "single_pop");
    chk("single.valid_after", 32'(word_valid), 32'h0);
    chk("single.count", 32'(word_count), 32'h1);

    // Same word with idle cycles between bits.
    pulse_reset();
    send_word(32'hA5A5F00F, 1'b1, 1, 1'b1, "gapped");
    chk("gapped.word", word_out, 32'hA5A5F00F);
    step(1'b0, 1'b0, 1'b1, "gapped_pop");

    // Overflow: five words into a four-deep FIFO, then drain.
    pulse_reset();
    for (int k = 1; k <= 5; k++) send_word(32'(k), 1'b0, 0, 1'b0, "ovf_fill");
    chk("ovf.flag", 32'(overflow), 32'h1);
    chk("ovf.count", 32'(word_count), 32'h4);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf.drain_valid", 32'(word_valid), 32'h1);
      chk("ovf.drain_word", word_out, 32'(k));
      step(1'b0, 1'b0, 1'b1, "ovf_drain");
    end
    chk("ovf.empty", 32'(word_valid), 32'h0);
    chk("ovf.sticky", 32'(overflow), 32'h1);

    // Full FIFO, push and pop on the same edge.
    pulse_reset();
    for (int k = 1; k <= 4; k++) send_word(32'(k), 1'b0, 0, 1'b0, "pp_fill");
    send_word(32'h6, 1'b0, 0, 1'b1, "pp_word6");
    chk("pp.overflow", 32'(overflow), 32'h0);
    chk("pp.count", 32'(word_count), 32'h5);
    for (int k = 0; k < 4; k++) begin
      chk("pp.drain_word", word_out, (k == 3) ? 32'h6 : 32'(k + 2));
      step(1'b0, 1'b0, 1'b1, "pp_drain");
    end
    chk("pp.empty", 32'(word_valid), 32'h0);

    // Reset in the middle of a word, then a fresh word and its signature.
    pulse_reset();
    for (int i = 0; i < 17; i++) step(1'($urandom), 1'b1, 1'b0, "partial");
    pulse_reset();
    send_word(32'h1, 1'b0, 0, 1'b0, "after_reset");
    chk("midreset.word", word_out, 32'h1);
    chk("midreset.count", 32'(word_count), 32'h1);
`ifdef LFSR_CAPTURE_SIGNATURE_EN
    chk("midreset.sig", sig_out, 32'h1);
`else
    chk("midreset.sig", sig_out, 32'h0);
`endif

    // Random traffic with an occasional reset.
    pulse_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) pulse_reset();
      step(1'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
